// File: rtl/spi_frame_pkg.sv
// Shared types and defaults for the SPI frame scheduler and its sample FIFO.
package spi_frame_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StSync     = 3'd1,
        StCount    = 3'd2,
        StPayHi    = 3'd3,
        StPayLo    = 3'd4,
        StChecksum = 3'd5
    } state_e;

    localparam logic [7:0] SyncByteDefault = 8'hA5;
    localparam logic [7:0] IdleByteDefault = 8'h00;

endpackage

// File: rtl/spi_frame_scheduler_fifo.sv
// Pass-through byte helper. Sample storage is implemented in spi_sample_fifo.sv;
// this module only forwards a single byte and has no other users.
module spi_frame_scheduler_fifo (
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);
    assign byte_o = byte_i;
endmodule

// File: rtl/spi_sample_fifo.sv
// Synchronous sample FIFO with first-word-fall-through head and a peek at the
// MSB byte of the entry behind the head.
module spi_sample_fifo #(
    parameter int unsigned Depth = 16,
    parameter int unsigned Width = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [Width-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         head_o,
    output logic [7:0]               next_msb_o,
    output logic [$clog2(Depth):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int unsigned AW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [AW-1:0]    rd_ptr_nx;

    assign rd_ptr_nx  = rd_ptr_q + AW'(1);
    assign head_o     = mem_q[rd_ptr_q];
    // Lets the scheduler present the next sample's MSB on the same edge it pops.
    assign next_msb_o = mem_q[rd_ptr_nx][Width-1 -: 8];
    assign count_o    = count_q;
    assign full_o     = (count_q == (AW+1)'(Depth));
    assign empty_o    = (count_q == '0);

    always_comb begin
        wr_ptr_d = push_i ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_i ? rd_ptr_nx : rd_ptr_q;
        count_d  = count_q;
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/spi_frame_scheduler.sv
// Frames buffered 16-bit samples as SYNC, COUNT, payload (MSB first), XOR checksum,
// advancing one byte per transmitter byte_sent pulse.
module spi_frame_scheduler
    import spi_frame_pkg::*;
#(
    parameter int unsigned FRAME_LEN  = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [7:0]  SYNC_BYTE  = SyncByteDefault,
    parameter logic [7:0]  IDLE_BYTE  = IdleByteDefault
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        in_ready,
    input  logic        start,
    input  logic        abort,
    input  logic        byte_sent,
    output logic [7:0]  tx_data,
    output logic        tx_enable,
    output logic        busy,
    output logic        frame_done,
    output logic        overflow
);
    localparam int unsigned CntW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CntW-1:0] FrameLenCnt  = CntW'(FRAME_LEN);
    localparam logic [7:0]      FrameLenByte = 8'(FRAME_LEN);

    state_e      state_q, state_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_enable_q, tx_enable_d;
    logic        frame_done_q, frame_done_d;
    logic        overflow_q, overflow_d;
    logic [7:0]  checksum_q, checksum_d;
    logic [7:0]  sample_cnt_q, sample_cnt_d;

    logic            fifo_push, fifo_pop_req, fifo_pop;
    logic [15:0]     fifo_head;
    logic [7:0]      fifo_next_msb;
    logic [CntW-1:0] fifo_count;
    logic            fifo_full, fifo_empty;

    assign fifo_push = in_valid && !fifo_full;
    assign fifo_pop  = fifo_pop_req && !fifo_empty;

    spi_sample_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (16)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (fifo_push),
        .wdata_i    (in_data),
        .pop_i      (fifo_pop),
        .head_o     (fifo_head),
        .next_msb_o (fifo_next_msb),
        .count_o    (fifo_count),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        tx_data_d    = tx_data_q;
        tx_enable_d  = tx_enable_q;
        frame_done_d = 1'b0;
        checksum_d   = checksum_q;
        sample_cnt_d = sample_cnt_q;
        fifo_pop_req = 1'b0;
        overflow_d   = overflow_q || (in_valid && fifo_full);

        // abort outranks byte_sent; the head sample is left in the FIFO
        if (abort && state_q != StIdle) begin
            state_d     = StIdle;
            tx_data_d   = IDLE_BYTE;
            tx_enable_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    tx_data_d = IDLE_BYTE;
                    if (start && fifo_count >= FrameLenCnt) begin
                        state_d      = StSync;
                        tx_data_d    = SYNC_BYTE;
                        tx_enable_d  = 1'b1;
                        checksum_d   = 8'h00;
                        sample_cnt_d = 8'h00;
                    end
                end
                StSync: if (byte_sent) begin
                    state_d    = StCount;
                    tx_data_d  = FrameLenByte;
                    checksum_d = checksum_q ^ FrameLenByte;
                end
                StCount: if (byte_sent) begin
                    state_d    = StPayHi;
                    tx_data_d  = fifo_head[15:8];
                    checksum_d = checksum_q ^ fifo_head[15:8];
                end
                StPayHi: if (byte_sent) begin
                    state_d    = StPayLo;
                    tx_data_d  = fifo_head[7:0];
                    checksum_d = checksum_q ^ fifo_head[7:0];
                end
                StPayLo: if (byte_sent) begin
                    fifo_pop_req = 1'b1;
                    sample_cnt_d = sample_cnt_q + 8'd1;
                    if (sample_cnt_d == FrameLenByte) begin
                        state_d   = StChecksum;
                        tx_data_d = checksum_q;
                    end else begin
                        state_d    = StPayHi;
                        tx_data_d  = fifo_next_msb;
                        checksum_d = checksum_q ^ fifo_next_msb;
                    end
                end
                StChecksum: if (byte_sent) begin
                    state_d      = StIdle;
                    tx_data_d    = IDLE_BYTE;
                    tx_enable_d  = 1'b0;
                    frame_done_d = 1'b1;
                end
                default: begin
                    state_d     = StIdle;
                    tx_data_d   = IDLE_BYTE;
                    tx_enable_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            tx_data_q    <= IDLE_BYTE;
            tx_enable_q  <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            checksum_q   <= 8'h00;
            sample_cnt_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            tx_data_q    <= tx_data_d;
            tx_enable_q  <= tx_enable_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            checksum_q   <= checksum_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_enable  = tx_enable_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
    assign busy       = (state_q != StIdle);
    assign in_ready   = !fifo_full;

endmodule

// File: tb/tb_spi_frame_scheduler.sv
// Scoreboard bench: expected bytes are queued from a sample model at frame start
// and popped/compared after each byte_sent pulse.
module tb_spi_frame_scheduler;
    localparam int unsigned FL = 2;
    localparam int unsigned FD = 16;

    typedef struct packed {
        logic [7:0] b;
        logic       pop;
        logic       last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, start, abort, byte_sent;
    logic [15:0] in_data;
    logic        in_ready, tx_enable, busy, frame_done, overflow;
    logic [7:0]  tx_data;

    logic [15:0] model_q [$];
    exp_t        exp_q [$];
    logic        ovf_exp;
    int          n_checks = 0;
    int          n_fail   = 0;

    spi_frame_scheduler #(
        .FRAME_LEN  (FL),
        .FIFO_DEPTH (FD),
        .SYNC_BYTE  (8'hA5),
        .IDLE_BYTE  (8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .start      (start),
        .abort      (abort),
        .byte_sent  (byte_sent),
        .tx_data    (tx_data),
        .tx_enable  (tx_enable),
        .busy       (busy),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_tx_en"}, tx_enable, 0);
        check_eq({tag, "_tx_data"}, tx_data, 8'h00);
        check_eq({tag, "_done"}, frame_done, 0);
    endtask

    task automatic push_sample(input logic [15:0] d);
        in_valid = 1'b1;
        in_data  = d;
        check_eq("in_ready", in_ready, model_q.size() < FD);
        step();
        in_valid = 1'b0;
        if (model_q.size() < FD) model_q.push_back(d);
        else ovf_exp = 1'b1;
        check_eq("overflow", overflow, ovf_exp);
    endtask

    task automatic build_expected();
        logic [7:0]  cs;
        logic [15:0] s;
        cs = 8'(FL);
        exp_q.push_back('{b: 8'(FL), pop: 1'b0, last: 1'b0});
        for (int i = 0; i < FL; i++) begin
            s = model_q[i];
            exp_q.push_back('{b: s[15:8], pop: (i != 0), last: 1'b0});
            exp_q.push_back('{b: s[7:0], pop: 1'b0, last: 1'b0});
            cs = cs ^ s[15:8] ^ s[7:0];
        end
        exp_q.push_back('{b: cs, pop: 1'b1, last: 1'b0});
        exp_q.push_back('{b: 8'h00, pop: 1'b0, last: 1'b1});
    endtask

    task automatic start_frame();
        bit enough;
        enough = (model_q.size() >= FL);
        start = 1'b1;
        step();
        start = 1'b0;
        if (enough) begin
            check_eq("start_busy", busy, 1);
            check_eq("start_sync", tx_data, 8'hA5);
            check_eq("start_en", tx_enable, 1);
            build_expected();
        end else begin
            check_idle("nostart");
        end
    endtask

    task automatic send_byte(input bit do_push, input logic [15:0] d);
        exp_t e;
        byte_sent = 1'b1;
        if (do_push) begin
            in_valid = 1'b1;
            in_data  = d;
            check_eq("sim_in_ready", in_ready, model_q.size() < FD);
        end
        step();
        byte_sent = 1'b0;
        in_valid  = 1'b0;
        if (do_push) begin
            if (model_q.size() < FD) model_q.push_back(d);
            else ovf_exp = 1'b1;
        end
        if (exp_q.size() == 0) begin
            check_eq("exp_available", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        if (e.pop) void'(model_q.pop_front());
        check_eq("tx_data", tx_data, e.b);
        check_eq("frame_done", frame_done, e.last);
        check_eq("tx_enable", tx_enable, !e.last);
        step();
        check_eq("tx_hold", tx_data, e.b);
        check_eq("done_pulse", frame_done, 0);
    endtask

    task automatic run_frame();
        start_frame();
        while (exp_q.size() > 0) send_byte(1'b0, 16'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        check_idle("rst");
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_overflow", overflow, 0);
        rst = 1'b0;
        model_q.delete();
        exp_q.delete();
        ovf_exp = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; in_valid = 0; in_data = 0; start = 0; abort = 0; byte_sent = 0;
        ovf_exp = 1'b0;
        step();
        do_reset();

        // Basic frame: A5,02,12,34,AB,CD,42
        push_sample(16'h1234);
        push_sample(16'hABCD);
        run_frame();
        check_eq("frame_empty_cnt", model_q.size(), 0);

        // Not enough samples while start is held
        push_sample(16'h5555);
        start = 1'b1;
        repeat (3) begin
            step();
            check_idle("short");
        end
        push_sample(16'h6666);
        check_eq("short_busy2", busy, 0);
        step();
        start = 1'b0;
        check_eq("late_busy", busy, 1);
        check_eq("late_sync", tx_data, 8'hA5);
        build_expected();
        while (exp_q.size() > 0) send_byte(1'b0, 16'h0);

        // Abort with byte_sent in PAY_HI of the second sample
        push_sample(16'h1111);
        push_sample(16'h2222);
        push_sample(16'h3333);
        start_frame();
        repeat (4) send_byte(1'b0, 16'h0);
        abort = 1'b1;
        byte_sent = 1'b1;
        step();
        abort = 1'b0;
        byte_sent = 1'b0;
        exp_q.delete();
        check_idle("abort");
        step();
        check_eq("abort_no_done", frame_done, 0);
        run_frame();

        // Overflow: 17 pushes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) push_sample(16'h1000 + 16'(i * 16'h0111));
        check_eq("full_ready", in_ready, 0);
        check_eq("full_ovf", overflow, 1);
        for (int f = 0; f < 8; f++) run_frame();
        check_eq("drained_ready", in_ready, 1);
        check_eq("ovf_sticky", overflow, 1);
        start_frame();

        // Reset in PAY_LO
        push_sample(16'hC0DE);
        push_sample(16'hF00D);
        start_frame();
        repeat (3) send_byte(1'b0, 16'h0);
        check_eq("paylo_busy", busy, 1);
        do_reset();
        start_frame();

        // Push and pop together at count FD-1
        for (int i = 0; i < FD - 1; i++) push_sample(16'h2000 + 16'(i * 16'h0203));
        start_frame();
        repeat (3) send_byte(1'b0, 16'h0);
        send_byte(1'b1, 16'hBEEF);
        check_eq("simul_ready", in_ready, 1);
        while (exp_q.size() > 0) send_byte(1'b0, 16'h0);
        while (model_q.size() >= FL) run_frame();
        check_eq("final_ready", in_ready, 1);
        check_eq("final_ovf", overflow, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
